// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event controller.
// Parser states, prefix/discard bytes, tracked-key table and the queued event layout.
package ps2_pkg;

    typedef logic [1:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE    = 2'd0;
    localparam ps2_state_t ST_EXT     = 2'd1;
    localparam ps2_state_t ST_BRK     = 2'd2;
    localparam ps2_state_t ST_EXT_BRK = 2'd3;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_R     = 8'h2D;

    localparam logic [2:0] IDX_UP    = 3'd0;
    localparam logic [2:0] IDX_DOWN  = 3'd1;
    localparam logic [2:0] IDX_LEFT  = 3'd2;
    localparam logic [2:0] IDX_RIGHT = 3'd3;
    localparam logic [2:0] IDX_SPACE = 3'd4;
    localparam logic [2:0] IDX_ENTER = 3'd5;
    localparam logic [2:0] IDX_ESC   = 3'd6;
    localparam logic [2:0] IDX_R     = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int EVT_W = $bits(ps2_evt_t);

    // Keyboard self-test / ack / resend / pause bytes that never form key events.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFE) || (b == 8'hFF) || (b == 8'hE1);
    endfunction

    // Returns {hit, bitmap index} for the held-key bitmap.
    function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
        logic [3:0] r;
        r = 4'b0000;
        if (ext) begin
            case (code)
                KEY_UP:    r = {1'b1, IDX_UP};
                KEY_DOWN:  r = {1'b1, IDX_DOWN};
                KEY_LEFT:  r = {1'b1, IDX_LEFT};
                KEY_RIGHT: r = {1'b1, IDX_RIGHT};
                default:   r = 4'b0000;
            endcase
        end else begin
            case (code)
                KEY_SPACE: r = {1'b1, IDX_SPACE};
                KEY_ENTER: r = {1'b1, IDX_ENTER};
                KEY_ESC:   r = {1'b1, IDX_ESC};
                KEY_R:     r = {1'b1, IDX_R};
                default:   r = 4'b0000;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event queue with registered show-ahead head; a push into a full queue is dropped
// unless a pop frees a slot in the same cycle.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d, remain;
    logic          valid_q, valid_d;
    logic [W-1:0]  head_q, head_d;
    logic          empty, full, pop_ok, push_ok;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CW'(DEPTH));
        pop_ok  = pop_i && !empty;
        push_ok = push_i && (!full || pop_ok);
        drop_o  = push_i && !push_ok;
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
        remain  = cnt_q - CW'(pop_ok);
        valid_d = (cnt_d != '0);
        // Head comes from an older stored entry if one survives, else from the incoming push.
        if (remain != '0) begin
            head_d = mem_q[rd_d];
        end else if (push_ok) begin
            head_d = data_i;
        end else begin
            head_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code parser: turns E0/F0-prefixed byte streams into queued key events and a held-key bitmap.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of already-held tracked keys.
//
// state      | meaning
// ST_IDLE    | no prefix seen
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 F0 seen
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [7:0] key_held,
    output logic       overflow,
    input  logic       clear_overflow
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

    ps2_state_t    state_q, state_d, cur_state;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    held_q, held_d;
    logic          ovf_q, ovf_d;
    logic          timed_out, fire, suppress, push, drop;
    logic          key_hit;
    logic [2:0]    key_idx;
    ps2_evt_t      evt_new, head;
    logic [EVT_W-1:0] head_w;

    always_comb begin
        timed_out = (state_q != ST_IDLE) && (tmr_q == TMO);
        cur_state = timed_out ? ST_IDLE : state_q;
        state_d   = cur_state;
        fire      = 1'b0;
        evt_new   = '{ext: 1'b0, brk: 1'b0, code: received_data};
        if (received_data_en) begin
            case (cur_state)
                ST_IDLE: begin
                    if (received_data == BYTE_EXT) begin
                        state_d = ST_EXT;
                    end else if (received_data == BYTE_BRK) begin
                        state_d = ST_BRK;
                    end else if (!is_discard(received_data)) begin
                        fire = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (received_data == BYTE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (received_data != BYTE_EXT) begin
                        fire        = 1'b1;
                        evt_new.ext = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    if (received_data != BYTE_BRK) begin
                        fire        = 1'b1;
                        evt_new.ext = (cur_state == ST_EXT_BRK);
                        evt_new.brk = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            endcase
        end
        tmr_d = (received_data_en || cur_state == ST_IDLE) ? '0 : tmr_q + TW'(1);
    end

    assign {key_hit, key_idx} = key_lookup(evt_new.ext, evt_new.code);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign suppress = fire && key_hit && !evt_new.brk && held_q[key_idx];
`else
    assign suppress = 1'b0;
`endif

    assign push = fire && !suppress;

    always_comb begin
        held_d = held_q;
        if (fire && key_hit) begin
            held_d[key_idx] = !evt_new.brk;
        end
        // A drop in the same cycle as a clear leaves the flag set.
        ovf_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (EVT_W)
    ) u_fifo (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .push_i (push),
        .data_i (evt_new),
        .pop_i  (evt_ready),
        .valid_o(evt_valid),
        .data_o (head_w),
        .drop_o (drop)
    );

    assign head      = head_w;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench for ps2_key_event_ctrl: stimulus pushes expected events, a monitor pops and compares.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       en = 1'b0;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic       evt_valid, evt_ext, evt_break, overflow;
    logic [7:0] evt_code, key_held;

    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50        (clk),
        .reset           (rst),
        .received_data   (data),
        .received_data_en(en),
        .evt_valid       (evt_valid),
        .evt_ready       (ready),
        .evt_code        (evt_code),
        .evt_ext         (evt_ext),
        .evt_break       (evt_break),
        .key_held        (key_held),
        .overflow        (overflow),
        .clear_overflow  (clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: an event is consumed at the next edge whenever valid && ready.
    always @(negedge clk) begin
        logic [9:0] got, e;
        if (!rst && evt_valid && ready) begin
            got = {evt_ext, evt_break, evt_code};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL evt_unexpected: got %h, required none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL evt_value: got %h, required %h", got, e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic c = 1'b0);
        @(posedge clk); #1;
        data = b; en = 1'b1; clr = c;
        @(posedge clk); #1;
        en = 1'b0; clr = 1'b0;
    endtask

    task automatic expect_evt(input logic x, input logic k, input logic [7:0] c);
        exp_q.push_back({x, k, c});
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_pending"}, exp_q.size(), 0);
        chk({nm, "_valid_low"}, evt_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] codes [6];
        codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_ext_brk", {evt_ext, evt_break}, 0);
        chk("rst_held", key_held, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        ready = 1'b1;

        // Plain make, then extended break of an untracked-then-tracked key
        expect_evt(0, 0, 8'h1D); send(8'h1D);
        expect_evt(1, 1, 8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain("seq1");
        chk("seq1_held", key_held[0], 0);

        // UP press: event visible the cycle after the strobe edge
        expect_evt(1, 0, 8'h75); send(8'hE0); send(8'h75);
        chk("up_latency", evt_valid, 1);
        chk("up_head", {evt_ext, evt_break, evt_code}, 10'h275);
        chk("up_held", key_held, 8'h01);
        expect_evt(1, 1, 8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain("up");
        chk("up_release_held", key_held, 8'h00);

        // Overflow: six makes into a stalled depth-4 queue
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH) expect_evt(0, 0, codes[i]);
            send(codes[i]);
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_head", evt_code, 8'h15);
        // Push into full queue with a simultaneous pop must land
        expect_evt(0, 0, 8'h36);
        @(posedge clk); #1;
        ready = 1'b1; data = 8'h36; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        drain("ovf");
        chk("ovf_sticky", overflow, 1);
        send(8'h00, 1'b1);
        chk("ovf_clear", overflow, 0);

        // Drop and clear in the same cycle: set wins
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expect_evt(0, 0, codes[i]);
            send(codes[i]);
        end
        send(8'h3D, 1'b1);
        chk("ovf_set_wins", overflow, 1);
        ready = 1'b1;
        drain("ovf2");
        send(8'h00, 1'b1);
        chk("ovf_clear2", overflow, 0);

        // Prefix timeout discards the pending E0
        send(8'hE0);
        repeat (TMO + 5) @(posedge clk);
        expect_evt(0, 0, 8'h29); send(8'h29);
        drain("tmo");
        chk("tmo_held", key_held, 8'h10);

        // Typematic repeats
        expect_evt(0, 1, 8'h29); send(8'hF0); send(8'h29);
        expect_evt(0, 0, 8'h29);
`ifndef PS2_TYPEMATIC_FILTER_EN
        expect_evt(0, 0, 8'h29);
        expect_evt(0, 0, 8'h29);
`endif
        send(8'h29); send(8'h29); send(8'h29);
        drain("rep");
        chk("rep_held", key_held, 8'h10);

        // Reset mid-prefix, then discard bytes
        send(8'hF0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_held", key_held, 8'h00);
        rst = 1'b0;
        expect_evt(0, 0, 8'h5A); send(8'h5A);
        send(8'hFA); send(8'hAA);
        drain("post_rst");
        chk("post_rst_held", key_held, 8'h20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
